// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the RAM arbiter
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// rtl/mem_arb_rsp_pipe.sv - read-return tag pipeline steering RVALID to the issuing requester
module mem_arb_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic id,
  output logic rvalid0,
  output logic rvalid1
);

  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      tag <= '0;
    end else begin
      vld[0] <= load;
      tag[0] <= id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign rvalid0 = vld[RD_LAT-1] && (tag[RD_LAT-1] == REQ_CPU);
  assign rvalid1 = vld[RD_LAT-1] && (tag[RD_LAT-1] == REQ_LDR);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-master arbiter for a single-port synchronous RAM
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          R0_REQ,
  input  logic          R0_WE,
  input  logic          R0_LOCK,
  input  logic [AW-1:0] R0_ADDR,
  input  logic [DW-1:0] R0_WDATA,
  output logic          R0_GNT,
  output logic          R0_RVALID,
  output logic [DW-1:0] R0_RDATA,
  input  logic          R1_REQ,
  input  logic          R1_WE,
  input  logic          R1_LOCK,
  input  logic [AW-1:0] R1_ADDR,
  input  logic [DW-1:0] R1_WDATA,
  output logic          R1_GNT,
  output logic          R1_RVALID,
  output logic [DW-1:0] R1_RDATA,
  output logic [AW-1:0] ADDRESS,
  output logic [DW-1:0] DATA,
  output logic          WREN,
  input  logic [DW-1:0] Q
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

  arb_state_t    state;
  logic          owner;
  logic          last;
  logic [CW-1:0] lock_cnt;

  logic sel_valid;
  logic sel_id;
  logic sel_we;
  logic sel_lock;
  logic owner_req;

  // A requesting owner excludes the other master; once it drops REQ, normal arbitration applies.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = REQ_CPU;
    owner_req = (owner == REQ_LDR) ? R1_REQ : R0_REQ;
    if (!RST) begin
      if (state == LOCKED && owner_req) begin
        if (lock_cnt < MAX_CNT) begin
          sel_valid = 1'b1;
          sel_id    = owner;
        end
      end else if (R0_REQ && R1_REQ) begin
        sel_valid = 1'b1;
        sel_id    = ~last;
      end else if (R0_REQ) begin
        sel_valid = 1'b1;
        sel_id    = REQ_CPU;
      end else if (R1_REQ) begin
        sel_valid = 1'b1;
        sel_id    = REQ_LDR;
      end
    end
  end

  assign sel_we   = (sel_id == REQ_LDR) ? R1_WE : R0_WE;
  assign sel_lock = (sel_id == REQ_LDR) ? R1_LOCK : R0_LOCK;

  assign R0_GNT  = sel_valid && (sel_id == REQ_CPU);
  assign R1_GNT  = sel_valid && (sel_id == REQ_LDR);
  assign WREN    = sel_valid && sel_we;
  assign ADDRESS = !sel_valid ? '0 : (sel_id == REQ_LDR) ? R1_ADDR : R0_ADDR;
  assign DATA    = !sel_valid ? '0 : (sel_id == REQ_LDR) ? R1_WDATA : R0_WDATA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= REQ_CPU;
      last     <= REQ_LDR;
      lock_cnt <= '0;
    end else if (sel_valid) begin
      last <= sel_id;
      if (state == LOCKED && sel_id == owner) begin
        if (!sel_lock || (lock_cnt + 1'b1) >= MAX_CNT) begin
          state    <= IDLE;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end else if (sel_lock && MAX_LOCK > 1) begin
        state    <= LOCKED;
        owner    <= sel_id;
        lock_cnt <= CW'(1);
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end else if (state == LOCKED) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end
  end

  mem_arb_rsp_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rsp_pipe (
    .clk    (CLK),
    .rst    (RST),
    .load   (sel_valid && !sel_we),
    .id     (sel_id),
    .rvalid0(R0_RVALID),
    .rvalid1(R1_RVALID)
  );

  assign R0_RDATA = Q;
  assign R1_RDATA = Q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a RAM model
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_req, r0_we, r0_lock;
  logic [15:0] r0_addr, r0_wdata;
  logic        r1_req, r1_we, r1_lock;
  logic [15:0] r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [15:0] r0_rdata, r1_rdata;
  logic [15:0] address, data, q;
  logic        wren;

  int n_chk = 0;
  int n_err = 0;

  mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .MAX_LOCK(4)) dut (
    .CLK(clk), .RST(rst),
    .R0_REQ(r0_req), .R0_WE(r0_we), .R0_LOCK(r0_lock), .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata),
    .R0_GNT(r0_gnt), .R0_RVALID(r0_rvalid), .R0_RDATA(r0_rdata),
    .R1_REQ(r1_req), .R1_WE(r1_we), .R1_LOCK(r1_lock), .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata),
    .R1_GNT(r1_gnt), .R1_RVALID(r1_rvalid), .R1_RDATA(r1_rdata),
    .ADDRESS(address), .DATA(data), .WREN(wren), .Q(q)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read as 0xA000 + low address byte, write-first
  logic [15:0]  mem [0:255];
  logic [255:0] written;
  always @(posedge clk) begin
    if (rst) begin
      written <= '0;
    end else if (wren) begin
      mem[address[7:0]]     <= data;
      written[address[7:0]] <= 1'b1;
    end
    if (wren)
      q <= data;
    else if (written[address[7:0]] && !rst)
      q <= mem[address[7:0]];
    else
      q <= 16'hA000 + {8'h00, address[7:0]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [15:0] prev_addr;
  logic [7:0]  a0, a1;
  logic        eg;

  initial begin
    clk = 0; rst = 1;
    r0_req = 1; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 1; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;

    // reset held two cycles with both requesting
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_gnt", {r1_gnt, r0_gnt}, 2'b00);
      chk("rst_wren", wren, 1'b0);
      chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
      chk("rst_addr", address, 16'h0000);
    end
    @(negedge clk); rst = 0; r0_addr = 16'h0001; r1_addr = 16'h0002; #1;
    chk("first_tie_gnt", {r1_gnt, r0_gnt}, 2'b01);
    chk("first_tie_addr", address, 16'h0001);
    @(negedge clk); r0_req = 0; #1;
    chk("second_gnt", {r1_gnt, r0_gnt}, 2'b10);
    chk("second_addr", address, 16'h0002);
    chk("r0_rvalid_1", {r1_rvalid, r0_rvalid}, 2'b01);
    chk("r0_rdata_1", r0_rdata, 16'hA001);
    @(negedge clk); r1_req = 0; #1;
    chk("r1_rvalid_1", {r1_rvalid, r0_rvalid}, 2'b10);
    chk("r1_rdata_1", r1_rdata, 16'hA002);
    chk("idle_gnt", {r1_gnt, r0_gnt}, 2'b00);

    // CPU write then read back
    @(negedge clk); r0_req = 1; r0_we = 1; r0_addr = 16'h0010; r0_wdata = 16'hBEEF; #1;
    chk("wr_gnt", r0_gnt, 1'b1);
    chk("wr_wren", wren, 1'b1);
    chk("wr_addr", address, 16'h0010);
    chk("wr_data", data, 16'hBEEF);
    @(negedge clk); r0_we = 0; #1;
    chk("rd_gnt", r0_gnt, 1'b1);
    chk("rd_wren", wren, 1'b0);
    chk("wr_no_rsp", {r1_rvalid, r0_rvalid}, 2'b00);
    @(negedge clk); r0_req = 0; #1;
    chk("rd_rvalid", {r1_rvalid, r0_rvalid}, 2'b01);
    chk("rd_rdata", r0_rdata, 16'hBEEF);
    @(negedge clk); #1;
    chk("rd_rvalid_once", {r1_rvalid, r0_rvalid}, 2'b00);

    // both reading continuously: alternation, R1 first since R0 was last
    a0 = 0; a1 = 0; prev_addr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r0_req = 1; r1_req = 1; r0_we = 0; r1_we = 0;
      r0_addr = 16'h0040 + {8'h00, a0};
      r1_addr = 16'h0080 + {8'h00, a1};
      #1;
      eg = (i % 2 == 0);
      chk("alt_gnt", {r1_gnt, r0_gnt}, eg ? 2'b10 : 2'b01);
      if (i > 0) begin
        chk("alt_rvalid", {r1_rvalid, r0_rvalid}, eg ? 2'b01 : 2'b10);
        chk("alt_rdata", eg ? r0_rdata : r1_rdata, 16'hA000 + prev_addr);
      end
      prev_addr = eg ? r1_addr : r0_addr;
      if (eg) a1++; else a0++;
    end
    @(negedge clk); r0_req = 0; r1_req = 0; #1;
    chk("alt_last_rvalid", {r1_rvalid, r0_rvalid}, 2'b01);
    chk("alt_last_rdata", r0_rdata, 16'hA000 + prev_addr);

    // R1 holds LOCK: four consecutive grants, then R0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        r1_req = 1; r1_lock = 1; r1_addr = 16'h0030;
        r0_req = 1; r0_addr = 16'h0031;
      end
      #1;
      chk("lock_gnt", {r1_gnt, r0_gnt}, (i < 4) ? 2'b10 : 2'b01);
    end
    @(negedge clk); r0_req = 0; r1_req = 0; r1_lock = 0; #1;
    chk("lock_r0_rvalid", {r1_rvalid, r0_rvalid}, 2'b01);
    chk("lock_r0_rdata", r0_rdata, 16'hA031);

    // R1 locked read-modify-write of 0x0020 while R0 reads 0x0020
    @(negedge clk);
    r1_req = 1; r1_we = 0; r1_lock = 1; r1_addr = 16'h0020;
    r0_req = 1; r0_we = 0; r0_addr = 16'h0020;
    #1;
    chk("rmw_rd_gnt", {r1_gnt, r0_gnt}, 2'b10);
    @(negedge clk); r1_we = 1; r1_wdata = 16'hA021; r1_lock = 0; #1;
    chk("rmw_wr_gnt", {r1_gnt, r0_gnt}, 2'b10);
    chk("rmw_wren", wren, 1'b1);
    chk("rmw_wdata", data, 16'hA021);
    chk("rmw_rvalid", {r1_rvalid, r0_rvalid}, 2'b10);
    chk("rmw_rdata", r1_rdata, 16'hA020);
    @(negedge clk); r1_req = 0; r1_we = 0; #1;
    chk("rmw_r0_gnt", {r1_gnt, r0_gnt}, 2'b01);
    @(negedge clk); r0_req = 0; #1;
    chk("rmw_final_rvalid", {r1_rvalid, r0_rvalid}, 2'b01);
    chk("rmw_final_data", r0_rdata, 16'hA021);

    // reset while R1 owns a lock with a read just accepted
    @(negedge clk); r1_req = 1; r1_lock = 1; r1_addr = 16'h0007; #1;
    chk("pre_rst_gnt", {r1_gnt, r0_gnt}, 2'b10);
    @(negedge clk); rst = 1; r0_req = 1; r0_addr = 16'h0008; #1;
    chk("in_rst_gnt", {r1_gnt, r0_gnt}, 2'b00);
    chk("in_rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b10);
    @(negedge clk); rst = 0; r1_lock = 0; #1;
    chk("post_rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
    chk("post_rst_gnt", {r1_gnt, r0_gnt}, 2'b01);
    @(negedge clk); r0_req = 0; r1_req = 0; #1;
    chk("post_rst_rd_rvalid", {r1_rvalid, r0_rvalid}, 2'b01);
    chk("post_rst_rd_data", r0_rdata, 16'hA008);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port synchronous RAM between the CPU and a secondary requester (program loader/DMA). Sits between both masters and the RAM's ADDRESS/DATA/WREN/Q pins. Issues at most one access per cycle using round-robin selection with optional bounded locking for read-modify-write sequences. Routes returned read data back to the issuing requester after the RAM read latency.

## Interface
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, RAM cycles from address-capture edge to valid Q (≥1)
- MAX_LOCK, 4, maximum consecutive grants to a locked owner (≥1)

- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- R0_REQ / R1_REQ  in  1  access request (R0 = CPU, R1 = loader)
- R0_WE / R1_WE  in  1  1 = write, 0 = read
- R0_LOCK / R1_LOCK  in  1  request to keep ownership after this grant
- R0_ADDR / R1_ADDR  in  AW  access address
- R0_WDATA / R1_WDATA  in  DW  write data
- R0_GNT / R1_GNT  out  1  access accepted at this rising edge
- R0_RVALID / R1_RVALID  out  1  read data valid, one cycle per read
- R0_RDATA / R1_RDATA  out  DW  read data (Q); valid only with RVALID
- ADDRESS  out  AW  RAM address
- DATA  out  DW  RAM write data
- WREN  out  1  RAM write enable
- Q  in  DW  RAM read data

## Operation
- Handshake: requester holds REQ, WE, LOCK, ADDR, WDATA stable until it samples GNT=1 at a rising edge; REQ&GNT at an edge = accepted transfer. Requester may issue back-to-back (REQ held, new ADDR after each GNT).
- GNT is combinational from REQ and registered arbiter state; at most one GNT high per cycle. ADDRESS/DATA/WREN are muxed from the granted requester; with no grant: WREN=0, ADDRESS=0, DATA=0.
- FSM states: IDLE (no owner) and LOCKED (owner register valid).
- IDLE: one requester → grant it. Both → grant the one that is not LAST (LAST = last granted requester, reset to 1 so CPU wins first tie). Winner's LOCK=1 at grant → LOCKED, owner=winner, lock_cnt=1.
- LOCKED: only owner eligible while owner REQ=1 and lock_cnt<MAX_LOCK; each owner grant increments lock_cnt. Exit to IDLE when owner grant occurs with LOCK=0, owner drops REQ, or lock_cnt reaches MAX_LOCK. Exit evaluated same cycle: other requester may be granted in the exit cycle only if owner REQ=0.
- LAST updates on every grant.
- Read return: a RD_LAT-deep tag pipeline (valid bit + requester id) is loaded on each read grant; at pipeline output, assert that requester's RVALID for one cycle; both RDATA ports carry Q unconditionally. Writes produce no response. Reads and writes pipeline freely; no stall on outstanding reads.

## Timing
- Reset values: all GNT=0, all RVALID=0, WREN=0, ADDRESS=0, DATA=0, state=IDLE, LAST=1, lock_cnt=0, tag pipeline cleared.
- RST mid-operation: in-flight read responses discarded (no RVALID after reset), lock released.
- Grant latency: 0 cycles (GNT in same cycle as REQ if eligible).
- Read latency: read accepted at edge k → RVALID high during cycle k+RD_LAT (RD_LAT=1: the cycle directly after the accepting edge).
- Throughput: one access per cycle; both requesters continuously requesting without LOCK alternate every cycle.
- Write to address A accepted at edge k followed by read of A at edge k+1 returns new data (RAM write-first ordering is the RAM's property; arbiter preserves issue order).

## Structure
- Package mem_arb_pkg: state enum (IDLE, LOCKED), requester id constants (REQ_CPU=0, REQ_LDR=1), default AW/DW.
- Sub-module mem_arb_rsp_pipe: parameterised RD_LAT-deep valid/id shift register producing per-requester RVALID; arbitration, FSM and mux in top.

## Test plan
- Reset: RST=1 two cycles with both REQ high → all GNT=0, WREN=0, RVALID=0; first cycle after release both REQ → R0_GNT=1.
- Single CPU write 0x0010←0xBEEF then read 0x0010 → WREN=1 one cycle, R0_RVALID one cycle after read grant, R0_RDATA=0xBEEF, R1_RVALID stays 0.
- Both requesters reading continuously without LOCK → GNT alternates R0,R1,R0,R1; each RVALID follows its own grant by RD_LAT, correct data per address.
- R1 holds LOCK with REQ while R0 requests, MAX_LOCK=4 → exactly 4 consecutive R1 grants, then R0 granted.
- R1 locked read-modify-write (read 0x0020, write 0x0020 with LOCK then 0) while R0 requests → R0 not granted until R1 write accepted; final RAM value is R1's write.
- Read accepted, RST asserted next edge → no RVALID after reset; state IDLE, LAST=1.
